// File: rtl/pb_debounce_multi.sv
// Multi-channel push-button conditioner: two-flop synchroniser, symmetric
// window debounce, and single-cycle press / release / long-press events.
module pb_debounce_multi #(
    parameter int unsigned CH         = 4,
    parameter int unsigned WIN        = 4,
    parameter int unsigned DIV        = 1,
    parameter int unsigned HOLD_TICKS = 0,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] pb_in,
    output logic [CH-1:0] pb_level,
    output logic [CH-1:0] pb_press,
    output logic [CH-1:0] pb_release,
    output logic [CH-1:0] pb_hold,
    output logic          sample_tick
);

    localparam int unsigned WW = $clog2(WIN + 1);
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic        IDLE_RAW = ACTIVE_LOW;

    logic [CH-1:0] sync1;
    logic [CH-1:0] sync2;
    logic [CH-1:0] sample_c;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_cnt_nxt_c;
    logic [WW-1:0] win_cnt [CH];

    // Synchroniser resets to the idle pin level so reset never looks like a press
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= {CH{IDLE_RAW}};
            sync2 <= {CH{IDLE_RAW}};
        end else begin
            sync1 <= pb_in;
            sync2 <= sync1;
        end
    end

    assign sample_c = ACTIVE_LOW ? ~sync2 : sync2;

    // Prescaler; the tick flop is loaded with the compare on the next count
    always_comb begin
        div_cnt_nxt_c = div_cnt + DW'(1);
        if (div_cnt == DW'(DIV - 1)) begin
            div_cnt_nxt_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            div_cnt     <= div_cnt_nxt_c;
            sample_tick <= (div_cnt_nxt_c == DW'(DIV - 1));
        end
    end

    // Window debounce: WIN consecutive disagreeing ticks flip the level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pb_level   <= '0;
            pb_press   <= '0;
            pb_release <= '0;
            for (int i = 0; i < CH; i++) begin
                win_cnt[i] <= '0;
            end
        end else begin
            pb_press   <= '0;
            pb_release <= '0;
            if (sample_tick) begin
                for (int i = 0; i < CH; i++) begin
                    if (sample_c[i] == pb_level[i]) begin
                        win_cnt[i] <= '0;
                    end else if (win_cnt[i] == WW'(WIN - 1)) begin
                        win_cnt[i]    <= '0;
                        pb_level[i]   <= ~pb_level[i];
                        pb_press[i]   <= ~pb_level[i];
                        pb_release[i] <= pb_level[i];
                    end else begin
                        win_cnt[i] <= win_cnt[i] + WW'(1);
                    end
                end
            end
        end
    end

    if (HOLD_TICKS > 0) begin : g_hold
        logic [HW-1:0] hold_cnt [CH];

        // Saturating counter fires once per press, re-armed by the level dropping
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pb_hold <= '0;
                for (int i = 0; i < CH; i++) begin
                    hold_cnt[i] <= '0;
                end
            end else begin
                pb_hold <= '0;
                for (int i = 0; i < CH; i++) begin
                    if (!pb_level[i]) begin
                        hold_cnt[i] <= '0;
                    end else if (sample_tick && (hold_cnt[i] != HW'(HOLD_TICKS))) begin
                        hold_cnt[i] <= hold_cnt[i] + HW'(1);
                        pb_hold[i]  <= (hold_cnt[i] == HW'(HOLD_TICKS - 1));
                    end
                end
            end
        end
    end else begin : g_no_hold
        assign pb_hold = '0;
    end

endmodule
